// File: rtl/dmem_if.sv
// Data-port bus between a load/store initiator and dmem_responder.
// Optional byte enables exist only when DMEM_BYTE_EN is defined.
interface dmem_if;
  // Handshake: the initiator raises req with we/adr/wdata (and be) stable and
  // holds them until it sees ready. The responder accepts in IDLE and pulses
  // ready for one cycle when the access completes. Any req still high in the
  // cycle after ready starts a new transaction.
  logic        req;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wdata;
`ifdef DMEM_BYTE_EN
  logic [3:0]  be;
`endif
  logic [31:0] rdata;
  logic        ready;
  logic        misalign;

  modport master (
`ifdef DMEM_BYTE_EN
    output be,
`endif
    output req, we, adr, wdata,
    input  rdata, ready, misalign
  );

  modport slave (
`ifdef DMEM_BYTE_EN
    input  be,
`endif
    input  req, we, adr, wdata,
    output rdata, ready, misalign
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory that serves one load/store per handshake after
// WAIT_CYC wait states. Define DMEM_BYTE_EN to add per-byte store enables.
module dmem_responder #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  dmem_if.slave      bus,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYC);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_idx;
  logic [1:0]          r_lo;
  logic                r_we;
  logic [31:0]         r_wdata;
  logic [3:0]          r_be;
  logic [31:0]         r_rdata;
  logic                r_ready;
  logic                r_misalign;
  logic [31:0]         r_mem [0:(1<<ADDR_W)-1];

  logic                w_accept;
  logic                w_commit;
  logic [ADDR_W-1:0]   w_c_idx;
  logic [1:0]          w_c_lo;
  logic                w_c_we;
  logic [31:0]         w_c_wdata;
  logic [3:0]          w_c_be;
  logic [3:0]          w_bus_be;
  logic                w_aligned;
  logic [31:0]         w_rd_word;
  logic                w_unused_adr;

`ifdef DMEM_BYTE_EN
  assign w_bus_be = bus.be;
`else
  assign w_bus_be = 4'hF;
`endif

  // Upper address bits are dropped, so the byte space wraps.
  assign w_unused_adr = ^bus.adr[31:ADDR_W+2];

  assign w_accept = (r_state == S_IDLE) && bus.req;

  // Commit happens on the edge that enters DONE; with zero wait states that
  // is the accepting edge itself, so the request comes straight off the bus.
  assign w_commit = (w_accept && (LP_WAIT == 4'd0)) ||
                    ((r_state == S_WAIT) && (r_cnt == 4'd1));

  assign w_c_idx   = w_accept ? bus.adr[ADDR_W+1:2] : r_idx;
  assign w_c_lo    = w_accept ? bus.adr[1:0]        : r_lo;
  assign w_c_we    = w_accept ? bus.we              : r_we;
  assign w_c_wdata = w_accept ? bus.wdata           : r_wdata;
  assign w_c_be    = w_accept ? w_bus_be            : r_be;
  assign w_aligned = (w_c_lo == 2'b00);
  assign w_rd_word = r_mem[w_c_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_idx      <= '0;
      r_lo       <= 2'b00;
      r_we       <= 1'b0;
      r_wdata    <= 32'd0;
      r_be       <= 4'd0;
      r_rdata    <= 32'd0;
      r_ready    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_ready    <= w_commit;
      r_misalign <= w_commit && !w_aligned;
      r_rdata    <= (w_commit && !w_c_we && w_aligned) ? w_rd_word : 32'd0;

      if (w_commit && w_c_we && w_aligned) begin
        for (int b = 0; b < 4; b++) begin
          if (w_c_be[b]) r_mem[w_c_idx][8*b +: 8] <= w_c_wdata[8*b +: 8];
        end
      end

      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_idx   <= bus.adr[ADDR_W+1:2];
            r_lo    <= bus.adr[1:0];
            r_we    <= bus.we;
            r_wdata <= bus.wdata;
            r_be    <= w_bus_be;
            r_cnt   <= LP_WAIT;
            r_state <= (LP_WAIT == 4'd0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rdata    = r_rdata;
  assign bus.ready    = r_ready;
  assign bus.misalign = r_misalign;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU's data port: answers the core's load/store requests.
- Holds a word-addressed storage array and serves one request at a time through a req/ready handshake.
- Each request takes a programmable number of wait states, so the core can be exercised against slow memory.
- Sits between the datapath's data_adr/data_out/data_in nets and the controller's memory strobes.

Parameters:
- ADDR_W, 10, word-index width; array depth = 2**ADDR_W words of 32 bits.
- WAIT_CYC, 2, wait states inserted between acceptance and response; legal range 0..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  initiator request; held high with adr/we/wdata stable until ready is seen.
- we  input  1  1 = store, 0 = load; sampled at acceptance.
- adr  input  32  byte address; word index = adr[ADDR_W+1:2].
- wdata  input  32  store data; sampled at acceptance.
- rdata  output  32  load data; valid only in the ready cycle; registered.
- ready  output  1  one-cycle completion pulse; registered.
- misalign  output  1  high with ready when the accepted adr[1:0] != 0; registered.

Behaviour:
- Reset:
  - Clears the FSM to IDLE, the wait counter to 0, and ready, rdata and misalign to 0.
  - Does not clear array contents.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - When req=1, latch adr, we and wdata, and load the counter with WAIT_CYC.
  - Go to WAIT if WAIT_CYC > 0, else go straight to DONE.
  - When req=0, stay in IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, the next edge enters DONE.
  - req is ignored in this state.
- Entry to DONE (the same edge):
  - Store: the array word is written, unless the access is misaligned.
  - Load: rdata is loaded with the array word, or 0 if misaligned.
  - misalign is set from the latched adr[1:0].
- DONE:
  - ready = 1 for exactly this cycle.
  - For a store, rdata = 0.
  - Next state is always IDLE.
  - req is ignored in this state.
- Outside DONE: ready = 0, misalign = 0, and rdata returns to 0.
- Latency: req first high in IDLE at cycle t gives ready high in cycle t+WAIT_CYC+1.
- Back-to-back: req still high in the IDLE cycle after DONE is accepted as a new transaction. The initiator must drop req on the edge after it sees ready if it has nothing further to issue.
- Address bits above ADDR_W+1 are ignored, so the address space wraps modulo 2**(ADDR_W+2) bytes.
- Misaligned store: no array change, misalign = 1 with ready.
- Load from a word written in an earlier transaction returns the new value; there is no same-transaction forwarding case.
- Reset mid-transaction (WAIT or DONE):
  - Aborts the transaction and returns to IDLE with outputs cleared.
  - A store not yet committed (reset before DONE entry) is dropped.
  - A store already committed stays written.
- Reset has priority over every other transition in the same cycle.

Optional Feature:
- Macro DMEM_BYTE_EN.
- When defined:
  - Adds input be[3:0], sampled at acceptance.
  - A store writes only the bytes whose be bit is 1 (be[0] = bits 7:0).
  - be = 0000 completes normally with no change to the array.
  - Loads ignore be and return the full word.
- When undefined:
  - The port is absent.
  - Every aligned store writes all 4 bytes.

Test Plan:
- WAIT_CYC=2: after reset, hold ready=0, rdata=0 for 3 cycles; store adr=0x10, wdata=0xDEADBEEF at cycle 5 -> ready high only in cycle 8, misalign=0.
- Load adr=0x10 issued immediately after the store's ready -> ready 3 cycles after acceptance, rdata=0xDEADBEEF in that cycle only, 0 the next cycle.
- Store adr=0x12, wdata=0x12345678, then load 0x10 -> first transaction ends with misalign=1; load still returns 0xDEADBEEF.
- ADDR_W=10: store 0xCAFEF00D to adr=0x1010, load adr=0x0010 -> rdata=0xCAFEF00D (wrap).
- Assert rst in the first WAIT cycle of a store to adr=0x20, wdata=0x11111111 -> no ready pulse; a later load of 0x20 returns the prior value (0x00000000 after a bench preload of zero).
- DMEM_BYTE_EN defined: word 0x10 = 0xDEADBEEF, store wdata=0x000000AA with be=0001 -> a load returns 0xDEADBEAA; a load with be=0000 returns the full word.
